// File: rtl/mem_access_unit.sv
// Data-memory access stage: checks alignment, drives a variable-latency word
// handshake with byte enables, and registers load words for the extension stage.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic        MemWrite,
    input  logic [2:0]  MemFunct,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic        Busy,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [3:0]  MemBE,
    output logic [31:0] MemWData,
    input  logic        MemAck,
    input  logic [31:0] MemRData,
    output logic [31:0] Dout,
    output logic [2:0]  ExtFunct,
    output logic [1:0]  A1_A0,
    output logic        Valid,
    output logic        AddrErr,
    output logic        BusErr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t state_r, state_nxt_s;

    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [2:0]       funct_r, funct_nxt_s;
    logic [1:0]       a10_r, a10_nxt_s;
    logic             req_nxt_s, we_nxt_s, busy_nxt_s;
    logic [31:0]      addr_nxt_s, wdata_nxt_s, dout_nxt_s;
    logic [3:0]       be_nxt_s;
    logic [2:0]       ext_nxt_s;
    logic [1:0]       a1a0_nxt_s;
    logic             valid_nxt_s, aerr_nxt_s, berr_nxt_s;
    logic             misaligned_s, timeout_s;

    function automatic logic is_byte_f(input logic [2:0] funct);
        return (funct == 3'b001) || (funct == 3'b011);
    endfunction

    function automatic logic is_half_f(input logic [2:0] funct);
        return (funct == 3'b010) || (funct == 3'b100);
    endfunction

    function automatic logic misaligned_f(input logic [2:0] funct, input logic [1:0] a10);
        logic bad;
        if (is_byte_f(funct)) begin
            bad = 1'b0;
        end else if (is_half_f(funct)) begin
            bad = a10[0];
        end else begin
            bad = (a10 != 2'b00);
        end
        return bad;
    endfunction

    function automatic logic [3:0] be_f(input logic [2:0] funct, input logic [1:0] a10);
        logic [3:0] be;
        if (is_byte_f(funct)) begin
            be = 4'b0001 << a10;
        end else if (is_half_f(funct)) begin
            be = a10[1] ? 4'b1100 : 4'b0011;
        end else begin
            be = 4'b1111;
        end
        return be;
    endfunction

    function automatic logic [31:0] rep_f(input logic [2:0] funct, input logic [31:0] wd);
        logic [31:0] r;
        if (is_byte_f(funct)) begin
            r = {4{wd[7:0]}};
        end else if (is_half_f(funct)) begin
            r = {2{wd[15:0]}};
        end else begin
            r = wd;
        end
        return r;
    endfunction

    assign misaligned_s = misaligned_f(MemFunct, Addr[1:0]);
    assign timeout_s    = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; an ack beats a simultaneous timeout
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (Start && !misaligned_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (MemAck) begin
                    state_nxt_s = ST_DONE;
                end else if (timeout_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of all registered outputs; request fields are zero unless a request is live
    always_comb begin
        req_nxt_s   = 1'b0;
        we_nxt_s    = 1'b0;
        busy_nxt_s  = 1'b0;
        addr_nxt_s  = 32'h0000_0000;
        be_nxt_s    = 4'b0000;
        wdata_nxt_s = 32'h0000_0000;
        cnt_nxt_s   = '0;
        valid_nxt_s = 1'b0;
        aerr_nxt_s  = 1'b0;
        berr_nxt_s  = 1'b0;
        funct_nxt_s = funct_r;
        a10_nxt_s   = a10_r;
        dout_nxt_s  = Dout;
        ext_nxt_s   = ExtFunct;
        a1a0_nxt_s  = A1_A0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    if (misaligned_s) begin
                        aerr_nxt_s = 1'b1;
                    end else begin
                        req_nxt_s   = 1'b1;
                        busy_nxt_s  = 1'b1;
                        we_nxt_s    = MemWrite;
                        addr_nxt_s  = {Addr[31:2], 2'b00};
                        be_nxt_s    = be_f(MemFunct, Addr[1:0]);
                        wdata_nxt_s = MemWrite ? rep_f(MemFunct, WData) : 32'h0000_0000;
                        funct_nxt_s = MemFunct;
                        a10_nxt_s   = Addr[1:0];
                    end
                end else begin
                    aerr_nxt_s = 1'b0;
                end
            end
            ST_REQ: begin
                if (MemAck) begin
                    valid_nxt_s = 1'b1;
                    if (!MemWe) begin
                        dout_nxt_s = MemRData;
                        ext_nxt_s  = funct_r;
                        a1a0_nxt_s = a10_r;
                    end else begin
                        dout_nxt_s = Dout;
                    end
                end else if (timeout_s) begin
                    berr_nxt_s = 1'b1;
                end else begin
                    req_nxt_s   = 1'b1;
                    busy_nxt_s  = 1'b1;
                    we_nxt_s    = MemWe;
                    addr_nxt_s  = MemAddr;
                    be_nxt_s    = MemBE;
                    wdata_nxt_s = MemWData;
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                req_nxt_s = 1'b0;
            end
        endcase
    end

    // Output and capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= '0;
            funct_r  <= 3'b000;
            a10_r    <= 2'b00;
            MemReq   <= 1'b0;
            MemWe    <= 1'b0;
            Busy     <= 1'b0;
            MemAddr  <= 32'h0000_0000;
            MemBE    <= 4'b0000;
            MemWData <= 32'h0000_0000;
            Dout     <= 32'h0000_0000;
            ExtFunct <= 3'b000;
            A1_A0    <= 2'b00;
            Valid    <= 1'b0;
            AddrErr  <= 1'b0;
            BusErr   <= 1'b0;
        end else begin
            cnt_r    <= cnt_nxt_s;
            funct_r  <= funct_nxt_s;
            a10_r    <= a10_nxt_s;
            MemReq   <= req_nxt_s;
            MemWe    <= we_nxt_s;
            Busy     <= busy_nxt_s;
            MemAddr  <= addr_nxt_s;
            MemBE    <= be_nxt_s;
            MemWData <= wdata_nxt_s;
            Dout     <= dout_nxt_s;
            ExtFunct <= ext_nxt_s;
            A1_A0    <= a1a0_nxt_s;
            Valid    <= valid_nxt_s;
            AddrErr  <= aerr_nxt_s;
            BusErr   <= berr_nxt_s;
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory access stage that sits directly upstream of the load data-extension stage.
- Accepts one load/store command at a time and checks alignment.
- Drives a variable-latency word-wide data-memory handshake with byte enables and lane-replicated store data.
- For loads, registers the raw 32-bit memory word together with ExtFunct and A1_A0 so the extension stage can select and extend the byte/halfword.

Parameters:
TIMEOUT_CYCLES, 16, max cycles MemReq may stay high without MemAck before abort (≥1)
CNT_W, 5, width of timeout counter (must hold TIMEOUT_CYCLES)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
Start  input  1  command strobe, accepted only when Busy=0
MemWrite  input  1  1=store, 0=load
MemFunct  input  3  000 word; 001 byte unsigned; 010 half unsigned; 011 byte signed; 100 half signed; others = word
Addr  input  32  byte address
WData  input  32  store data (low byte/half used for sb/sh)
Busy  output  1  command in flight
MemReq  output  1  memory request, held until MemAck
MemWe  output  1  write qualifier, valid while MemReq=1
MemAddr  output  32  {Addr[31:2],2'b00}
MemBE  output  4  byte enables, bit i = byte lane i (Din[8i+7:8i])
MemWData  output  32  lane-replicated store data
MemAck  input  1  memory completion, single-cycle pulse
MemRData  input  32  read word, valid with MemAck
Dout  output  32  registered read word for the extension stage
ExtFunct  output  3  registered MemFunct of the last load
A1_A0  output  2  registered Addr[1:0] of the last load
Valid  output  1  one-cycle pulse: command completed
AddrErr  output  1  one-cycle pulse: misaligned command rejected
BusErr  output  1  one-cycle pulse: timeout abort

Behaviour:
- Reset (asynchronous, any state): state=IDLE; every output=0; counter=0.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - Start=1 → capture all command inputs and check alignment.
  - Misaligned: half (MemFunct 010/100) with Addr[0]=1, or word with Addr[1:0]≠00.
  - Misaligned → AddrErr=1 next cycle, no request, stay IDLE.
  - Aligned → REQ next cycle.
- Byte enables:
  - byte → 4'b0001<<Addr[1:0]
  - half → Addr[1]?4'b1100:4'b0011
  - word → 4'b1111
- Store data replication:
  - sb → {4{WData[7:0]}}
  - sh → {2{WData[15:0]}}
  - sw → WData
- REQ:
  - MemReq=1; MemWe, MemAddr, MemBE, MemWData stable; Busy=1; counter increments every cycle.
  - MemAck=1 → drop MemReq next cycle and go to DONE.
  - On a load, that same edge latches Dout←MemRData, ExtFunct←captured MemFunct, A1_A0←captured Addr[1:0].
  - Stores leave Dout, ExtFunct and A1_A0 unchanged.
  - counter reaching TIMEOUT_CYCLES with no MemAck → BusErr=1 one cycle, MemReq=0, go to IDLE; Dout unchanged.
  - MemAck and timeout on the same cycle → the ack wins.
- DONE: Valid=1 for exactly one cycle, Busy=0, then IDLE.
  - Start in DONE is accepted exactly as in IDLE (back-to-back).
- Minimum latency:
  - Start at cycle 0 → MemReq high in cycle 1.
  - MemAck in cycle 1 → Valid in cycle 2.
  - Throughput is one command per 2 cycles.
- Ignored inputs:
  - MemAck outside REQ is ignored.
  - Start while Busy=1 is ignored; the caller must hold the command.
- MemFunct 101–111 behave as word for alignment, enables and replication.
- Output holding:
  - MemAddr, MemBE, MemWData and MemWe are 0 when MemReq=0.
  - Dout, ExtFunct and A1_A0 hold until the next load completes.

Test Plan:
- Load word, Addr=0x100, MemAck after 3 cycles with MemRData=0xDEADBEEF → MemBE=1111, MemAddr=0x100, MemWe=0; Valid 1 cycle after ack; Dout=0xDEADBEEF, ExtFunct=000, A1_A0=00.
- sb, Addr=0x203, WData=0x000000A5, immediate ack → MemBE=1000, MemWData=0xA5A5A5A5, MemWe=1, Valid at cycle 2; Dout unchanged.
- lh at Addr=0x301 → AddrErr pulse, MemReq never asserted. lw at Addr=0x302 → same response.
- Load, no MemAck, TIMEOUT_CYCLES=4 → MemReq high 4 cycles, then BusErr pulse, IDLE, Dout unchanged. A late MemAck after the abort is ignored.
- Reset mid-REQ (rst_n low asynchronously) → MemReq, Busy and Valid drop immediately. A new command after release completes normally.
- Back-to-back: lbu at 0x401, ack with 0x11223344, Start in the DONE cycle with sh at 0x402 → second request in the next cycle, MemBE=1100; first load leaves ExtFunct=001, A1_A0=01, Dout=0x11223344.
